// File: rtl/lpr_cmd_pkg.sv
// Shared definitions for the license-plate accelerator command sequencer:
// opcodes, state encoding, error codes and status_word field positions.
package lpr_cmd_pkg;

    localparam logic [3:0] OP_NOP         = 4'd0;
    localparam logic [3:0] OP_START       = 4'd1;
    localparam logic [3:0] OP_ABORT       = 4'd2;
    localparam logic [3:0] OP_SOFT_RST    = 4'd3;
    localparam logic [3:0] OP_SET_TIMEOUT = 4'd4;
    localparam logic [3:0] OP_ACK_IRQ     = 4'd5;
    localparam logic [3:0] OP_SET_CFG     = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_ABORTING  = 3'd3,
        ST_SRST      = 3'd4
    } state_e;

    localparam logic [7:0] ERR_OK          = 8'h00;
    localparam logic [7:0] ERR_BUSY_REJECT = 8'h01;
    localparam logic [7:0] ERR_ACC_ERR     = 8'h02;
    localparam logic [7:0] ERR_TIMEOUT     = 8'h03;
    localparam logic [7:0] ERR_ABORTED     = 8'h04;
    localparam logic [7:0] ERR_BAD_OP      = 8'h06;

    localparam int STS_STATE_LSB = 29;
    localparam int STS_IRQ_BIT   = 28;
    localparam int STS_TAG_LSB   = 24;
    localparam int STS_ERR_LSB   = 16;
    localparam int STS_RES_LSB   = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [23:0] arg;
    } cmd_t;

endpackage

// File: rtl/lpr_watchdog.sv
// Loadable down-counter for the command timeout.
// Ports: load/load_val reload, en decrements, expired flags the cycle
// in which an enabled count steps from 1 to 0.
module lpr_watchdog #(
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [TIMEOUT_W-1:0] load_val,
    input  logic                 en,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - TIMEOUT_W'(1);
        end
    end

    assign expired = en && (count == TIMEOUT_W'(1));

endmodule

// File: rtl/lpr_cmd_sequencer.sv
// Command sequencer between the HPS command PIO and the accelerator.
// Ports: cmd_word in, status_word/irq/cfg_word out, acc_* handshakes.
module lpr_cmd_sequencer
    import lpr_cmd_pkg::*;
#(
    parameter int                   TIMEOUT_W       = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_DEFAULT = TIMEOUT_W'(24'hFFFFFF),
    parameter int                   SRST_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_word,
    output logic [31:0] status_word,
    output logic        irq,
    output logic [23:0] cfg_word,
    output logic        acc_start,
    output logic [23:0] acc_arg,
    output logic        acc_abort,
    output logic        acc_soft_rst,
    input  logic        acc_busy,
    input  logic        acc_done,
    input  logic        acc_err,
    input  logic [15:0] acc_result
);

    localparam int SRST_W =
        ($clog2(SRST_CYCLES) > 0) ? $clog2(SRST_CYCLES) : 1;

    state_e               state;
    state_e               next_state;
    cmd_t                 cmd_q;
    logic [3:0]           last_tag;
    logic [7:0]           err_code;
    logic [15:0]          result;
    logic [TIMEOUT_W-1:0] timeout_reg;
    logic [TIMEOUT_W-1:0] wd_load_val;
    logic [SRST_W-1:0]    srst_cnt;
    logic                 abort_first;
    logic                 wd_expired;
    logic                 new_cmd;
    logic                 take_cmd;
    logic                 done_hit;
    logic                 irq_set;
    logic                 enter_srst;

    // Commands arriving in ISSUE, ABORTING or SRST stay pending in cmd_q
    // because last_tag is left alone until a consuming state is reached.
    assign new_cmd  = (cmd_q.tag != last_tag);
    assign take_cmd = new_cmd &&
                      (state == ST_IDLE || state == ST_WAIT_DONE);
    assign done_hit = (state == ST_WAIT_DONE) && acc_done;
    assign irq_set  = done_hit || (state == ST_ABORTING && !acc_busy);
    assign enter_srst = (state != ST_SRST) && (next_state == ST_SRST);

    assign wd_load_val = (timeout_reg == '0) ? TIMEOUT_DEFAULT
                                             : timeout_reg;

    lpr_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (state == ST_ISSUE),
        .load_val (wd_load_val),
        .en       (state == ST_WAIT_DONE),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Done has priority over watchdog expiry and over an ABORT command.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (take_cmd && cmd_q.op == OP_START) begin
                    next_state = ST_ISSUE;
                end else if (take_cmd && cmd_q.op == OP_SOFT_RST) begin
                    next_state = ST_SRST;
                end
            end
            ST_ISSUE: begin
                next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (acc_done) begin
                    next_state = ST_IDLE;
                end else if (wd_expired) begin
                    next_state = ST_ABORTING;
                end else if (take_cmd && cmd_q.op == OP_ABORT) begin
                    next_state = ST_ABORTING;
                end
            end
            ST_ABORTING: begin
                if (!acc_busy) begin
                    next_state = ST_IDLE;
                end
            end
            ST_SRST: begin
                if (srst_cnt == '0) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        acc_start    = (state == ST_ISSUE);
        acc_abort    = (state == ST_ABORTING) && abort_first;
        acc_soft_rst = (state == ST_SRST);
        status_word  = '0;
        status_word[STS_STATE_LSB +: 3] = state;
        status_word[STS_IRQ_BIT]        = irq;
        status_word[STS_TAG_LSB +: 4]   = last_tag;
        status_word[STS_ERR_LSB +: 8]   = err_code;
        status_word[STS_RES_LSB +: 16]  = result;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q       <= '0;
            last_tag    <= '0;
            err_code    <= ERR_OK;
            result      <= '0;
            irq         <= 1'b0;
            cfg_word    <= '0;
            acc_arg     <= '0;
            timeout_reg <= TIMEOUT_DEFAULT;
            srst_cnt    <= '0;
            abort_first <= 1'b0;
        end else begin
            cmd_q       <= cmd_word;
            abort_first <= (state != ST_ABORTING) &&
                           (next_state == ST_ABORTING);

            if (take_cmd) begin
                last_tag <= cmd_q.tag;
                if (cmd_q.op == OP_SET_TIMEOUT) begin
                    timeout_reg <= TIMEOUT_W'(cmd_q.arg);
                end
                if (cmd_q.op == OP_SET_CFG) begin
                    cfg_word <= cmd_q.arg;
                end
            end

            if (state == ST_IDLE && take_cmd &&
                cmd_q.op == OP_START) begin
                acc_arg <= cmd_q.arg;
            end

            // A concurrent ACK_IRQ loses against a new interrupt.
            if (irq_set) begin
                irq <= 1'b1;
            end else if (take_cmd && cmd_q.op == OP_ACK_IRQ) begin
                irq <= 1'b0;
            end

            if (done_hit) begin
                result <= acc_result;
            end else if (enter_srst) begin
                result <= '0;
            end

            if (done_hit) begin
                err_code <= acc_err ? ERR_ACC_ERR : ERR_OK;
            end else if (state == ST_WAIT_DONE && wd_expired) begin
                err_code <= ERR_TIMEOUT;
            end else if (enter_srst) begin
                err_code <= ERR_OK;
            end else if (take_cmd) begin
                case (cmd_q.op)
                    OP_START: begin
                        err_code <= (state == ST_IDLE) ? ERR_OK
                                                       : ERR_BUSY_REJECT;
                    end
                    OP_SOFT_RST: begin
                        err_code <= ERR_BUSY_REJECT;
                    end
                    OP_ABORT: begin
                        if (state == ST_WAIT_DONE) begin
                            err_code <= ERR_ABORTED;
                        end
                    end
                    OP_NOP, OP_SET_TIMEOUT, OP_ACK_IRQ, OP_SET_CFG: begin
                        err_code <= err_code;
                    end
                    default: begin
                        err_code <= ERR_BAD_OP;
                    end
                endcase
            end

            if (enter_srst) begin
                srst_cnt <= SRST_W'(SRST_CYCLES - 1);
            end else if (state == ST_SRST && srst_cnt != '0) begin
                srst_cnt <= srst_cnt - SRST_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lpr_cmd_sequencer.sv
// Directed self-checking bench for lpr_cmd_sequencer.
// Inputs change 1 ns after posedge; outputs are checked there too.
module tb_lpr_cmd_sequencer;

    logic        clk;
    logic        reset_n;
    logic [31:0] cmd_word;
    logic [31:0] status_word;
    logic        irq;
    logic [23:0] cfg_word;
    logic        acc_start;
    logic [23:0] acc_arg;
    logic        acc_abort;
    logic        acc_soft_rst;
    logic        acc_busy;
    logic        acc_done;
    logic        acc_err;
    logic [15:0] acc_result;

    int n_cmp = 0;
    int n_err = 0;
    int hi_cnt;

    lpr_cmd_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_word     (cmd_word),
        .status_word  (status_word),
        .irq          (irq),
        .cfg_word     (cfg_word),
        .acc_start    (acc_start),
        .acc_arg      (acc_arg),
        .acc_abort    (acc_abort),
        .acc_soft_rst (acc_soft_rst),
        .acc_busy     (acc_busy),
        .acc_done     (acc_done),
        .acc_err      (acc_err),
        .acc_result   (acc_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] op, input logic [3:0] tag,
                       input logic [23:0] arg);
        cmd_word = {op, tag, arg};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        cmd_word   = '0;
        acc_busy   = 1'b0;
        acc_done   = 1'b0;
        acc_err    = 1'b0;
        acc_result = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_status", status_word, 32'h0);
        chk("rst_outs", {31'(0), irq}, 32'h0);
        chk("rst_cfg", 32'(cfg_word), 32'h0);
        chk("rst_pulses", {29'(0), acc_start, acc_abort, acc_soft_rst}, 0);
        reset_n = 1'b1;
        tick();

        // START tag 1, arg 0xABC, then complete with 0x1234
        put(4'd1, 4'd1, 24'hABC);
        tick();
        chk("start_lat1", 32'(acc_start), 32'h0);
        tick();
        chk("start_pulse", 32'(acc_start), 32'h1);
        chk("start_arg", 32'(acc_arg), 32'hABC);
        chk("issue_sts", status_word, 32'h2100_0000);
        tick();
        chk("start_once", 32'(acc_start), 32'h0);
        chk("wait_sts", status_word, 32'h4100_0000);
        acc_done = 1'b1;
        acc_result = 16'h1234;
        tick();
        acc_done = 1'b0;
        chk("done_sts", status_word, 32'h1100_1234);
        chk("done_irq", 32'(irq), 32'h1);

        // ACK_IRQ
        put(4'd5, 4'd2, 24'h0);
        tick();
        tick();
        chk("ack_sts", status_word, 32'h0200_1234);

        // SET_TIMEOUT 10, START, watchdog expiry while busy
        put(4'd4, 4'd3, 24'd10);
        tick();
        tick();
        put(4'd1, 4'd4, 24'h55);
        tick();
        tick();
        chk("to_issue", status_word, 32'h2400_1234);
        acc_busy = 1'b1;
        repeat (10) tick();
        chk("to_pre_abort", 32'(acc_abort), 32'h0);
        chk("to_pre_sts", status_word, 32'h4400_1234);
        tick();
        chk("to_abort", 32'(acc_abort), 32'h1);
        chk("to_abort_sts", status_word, 32'h6403_1234);
        repeat (4) tick();
        chk("to_abort_once", 32'(acc_abort), 32'h0);
        chk("to_busy_hold", status_word, 32'h6403_1234);
        acc_busy = 1'b0;
        tick();
        chk("to_idle", status_word, 32'h1403_1234);

        // ABORT command in WAIT_DONE
        put(4'd1, 4'd5, 24'h77);
        tick();
        tick();
        tick();
        put(4'd2, 4'd6, 24'h0);
        tick();
        tick();
        chk("ab_pulse", 32'(acc_abort), 32'h1);
        chk("ab_sts", status_word, 32'h7604_1234);
        tick();
        chk("ab_once", 32'(acc_abort), 32'h0);
        chk("ab_idle", status_word, 32'h1604_1234);

        // acc_done and ABORT evaluated in the same cycle
        put(4'd1, 4'd7, 24'h99);
        tick();
        tick();
        tick();
        put(4'd2, 4'd8, 24'h0);
        tick();
        acc_done = 1'b1;
        acc_result = 16'h5678;
        tick();
        acc_done = 1'b0;
        chk("dab_sts", status_word, 32'h1800_5678);
        chk("dab_noabort", 32'(acc_abort), 32'h0);
        tick();
        chk("dab_stay", status_word, 32'h1800_5678);

        // START while busy is rejected, then error completion
        put(4'd1, 4'd9, 24'h111);
        tick();
        tick();
        tick();
        put(4'd1, 4'd10, 24'h222);
        tick();
        tick();
        chk("rej_nostart", 32'(acc_start), 32'h0);
        chk("rej_sts", status_word, 32'h5A01_5678);
        chk("rej_arg", 32'(acc_arg), 32'h111);
        tick();
        chk("rej_nostart2", 32'(acc_start), 32'h0);
        acc_done = 1'b1;
        acc_err = 1'b1;
        acc_result = 16'h0BAD;
        tick();
        acc_done = 1'b0;
        acc_err = 1'b0;
        chk("accerr_sts", status_word, 32'h1A02_0BAD);

        // Illegal opcode, SET_CFG
        put(4'd9, 4'd11, 24'h0);
        tick();
        tick();
        chk("badop_sts", status_word, 32'h1B06_0BAD);
        put(4'd6, 4'd12, 24'hC0FFEE);
        tick();
        tick();
        chk("cfg", 32'(cfg_word), 32'hC0FFEE);

        // SOFT_RST with a SET_CFG queued during it
        put(4'd3, 4'd13, 24'h0);
        tick();
        tick();
        chk("srst_sts", status_word, 32'h9D00_0000);
        put(4'd6, 4'd14, 24'h123456);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (acc_soft_rst) hi_cnt++;
            if (i == 3) chk("srst_hold_cfg", 32'(cfg_word), 32'hC0FFEE);
            tick();
        end
        chk("srst_len", hi_cnt, 16);
        chk("srst_cfg_after", 32'(cfg_word), 32'h123456);
        chk("srst_idle", status_word, 32'h1E00_0000);

        // ACK_IRQ
        put(4'd5, 4'd15, 24'h0);
        tick();
        tick();
        chk("ack2_sts", status_word, 32'h0F00_0000);

        // Timeout of 1: expiry in the first WAIT_DONE cycle
        put(4'd4, 4'd0, 24'd1);
        tick();
        tick();
        put(4'd1, 4'd1, 24'h33);
        tick();
        tick();
        chk("t1_issue", status_word, 32'h2100_0000);
        tick();
        chk("t1_wait", status_word, 32'h4100_0000);
        tick();
        chk("t1_abort", 32'(acc_abort), 32'h1);
        chk("t1_abort_sts", status_word, 32'h6103_0000);
        tick();
        chk("t1_idle", status_word, 32'h1103_0000);

        // Asynchronous reset during soft reset
        put(4'd3, 4'd2, 24'h0);
        tick();
        tick();
        repeat (3) tick();
        chk("ar_srst_on", 32'(acc_soft_rst), 32'h1);
        cmd_word = '0;
        reset_n = 1'b0;
        #1;
        chk("ar_srst_off", 32'(acc_soft_rst), 32'h0);
        chk("ar_status", status_word, 32'h0);
        chk("ar_regs", {irq, cfg_word, 7'(0)}, 32'h0);
        chk("ar_arg", 32'(acc_arg), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Default timeout restored: no expiry within 20 cycles
        put(4'd1, 4'd1, 24'h5);
        tick();
        tick();
        repeat (20) tick();
        chk("ar_to_default", status_word, 32'h4100_0000);
        acc_done = 1'b1;
        acc_result = 16'h0042;
        tick();
        acc_done = 1'b0;
        chk("ar_done", status_word, 32'h1100_0042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
